slave_port_arbiter: RTL and testbench

- One instance per slave port of the 2-master/2-slave crossbar.
- Arbitrates master 0 and master 1 requests targeting this slave, round-robin, one transaction at a time.
- Muxes the winner's command onto the slave bus and returns the slave ack to the winner.
- Holds the per-master granted flag through a response window so the master-side response-return path sees a stable grant; a watchdog aborts transactions the slave never acks.

---
 rtl/slave_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_slave_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: round-robin 2:1 arbiter for one crossbar slave port,
// with a post-ack grant hold window and a BUSY-state watchdog.
module slave_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RESP_HOLD = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_cmd,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_cmd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic              m0_granted,
  output logic              m1_granted,
  output logic              sl_req,
  output logic [ADDR_W-1:0] sl_addr,
  output logic              sl_cmd,
  output logic [DATA_W-1:0] sl_wdata,
  input  logic              sl_ack,
  output logic              err,
  output logic              err_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] HLAST = 4'((RESP_HOLD > 0) ? RESP_HOLD - 1 : 0);

  state_t     state;
  logic       owner;
  logic       last;
  logic [7:0] timer;
  logic [3:0] hcnt;
  logic       own_req;
  logic       pick;
  logic       busy;

  assign busy    = (state == BUSY);
  assign own_req = owner ? m1_req : m0_req;

  // Tie goes to the master that did not finish last.
  assign pick = (m0_req & m1_req) ? ~last : m1_req;

  assign m0_ack = busy & ~owner & sl_ack;
  assign m1_ack = busy &  owner & sl_ack;

  // Owner's command onto the slave bus; zero when no transfer is live.
  always_comb begin
    sl_addr  = '0;
    sl_cmd   = 1'b0;
    sl_wdata = '0;
    if (busy) begin
      sl_addr  = owner ? m1_addr  : m0_addr;
      sl_cmd   = owner ? m1_cmd   : m0_cmd;
      sl_wdata = owner ? m1_wdata : m0_wdata;
    end
  end

  // Arbitration FSM with registered grant, request and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      m0_granted <= 1'b0;
      m1_granted <= 1'b0;
      sl_req     <= 1'b0;
      err        <= 1'b0;
      err_id     <= 1'b0;
      timer      <= '0;
      hcnt       <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            owner      <= pick;
            state      <= BUSY;
            sl_req     <= 1'b1;
            timer      <= '0;
            m0_granted <= ~pick;
            m1_granted <= pick;
          end
        end
        BUSY: begin
          if (sl_ack) begin
            last   <= owner;
            timer  <= '0;
            sl_req <= 1'b0;
            hcnt   <= '0;
            if (RESP_HOLD == 0) begin
              state      <= IDLE;
              m0_granted <= 1'b0;
              m1_granted <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else if (!own_req) begin
            last       <= owner;
            timer      <= '0;
            sl_req     <= 1'b0;
            state      <= IDLE;
            m0_granted <= 1'b0;
            m1_granted <= 1'b0;
          end else if (timer == TLAST) begin
            err        <= 1'b1;
            err_id     <= owner;
            last       <= owner;
            timer      <= '0;
            sl_req     <= 1'b0;
            state      <= IDLE;
            m0_granted <= 1'b0;
            m1_granted <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        HOLD: begin
          if (hcnt == HLAST) begin
            state      <= IDLE;
            m0_granted <= 1'b0;
            m1_granted <= 1'b0;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          sl_req     <= 1'b0;
          m0_granted <= 1'b0;
          m1_granted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb_slave_port_arbiter: randomized masters and slave against a
// transaction-level model; per-cycle expectations checked by a monitor.
module tb_slave_port_arbiter;

  localparam int RH = 2;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        sl_ack;
  logic        rq_a [2];
  logic        cm_a [2];
  logic [31:0] ad_a [2];
  logic [31:0] wd_a [2];

  logic        m0_ack, m1_ack, m0_granted, m1_granted;
  logic        sl_req, sl_cmd, err, err_id;
  logic [31:0] sl_addr, sl_wdata;

  slave_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RESP_HOLD(RH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(rq_a[0]), .m0_addr(ad_a[0]),
    .m0_cmd(cm_a[0]), .m0_wdata(wd_a[0]),
    .m1_req(rq_a[1]), .m1_addr(ad_a[1]),
    .m1_cmd(cm_a[1]), .m1_wdata(wd_a[1]),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_granted(m0_granted), .m1_granted(m1_granted),
    .sl_req(sl_req), .sl_addr(sl_addr),
    .sl_cmd(sl_cmd), .sl_wdata(sl_wdata),
    .sl_ack(sl_ack), .err(err), .err_id(err_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        g0, g1, a0, a1, rq, cmd, er, eid;
    logic [31:0] addr, wdata;
  } obs_t;

  obs_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  // reference model: transaction-level view of the port
  bit busy      = 0;
  int hold_left = 0;
  int own       = 0;
  int waited    = 0;
  int tie_to    = 0;
  bit err_now   = 0;
  int err_who   = 0;
  bit acked [2] = '{0, 0};

  task automatic step();
    obs_t e;
    int   reqs;
    reqs = (rq_a[1] ? 2 : 0) + (rq_a[0] ? 1 : 0);
    if (!rst_n) begin
      busy = 0; hold_left = 0; own = 0;
      waited = 0; tie_to = 0; err_now = 0;
    end
    e = '0;
    e.g0 = (busy || hold_left > 0) && own == 0;
    e.g1 = (busy || hold_left > 0) && own == 1;
    if (busy) begin
      e.rq    = 1'b1;
      e.addr  = ad_a[own];
      e.wdata = wd_a[own];
      e.cmd   = cm_a[own];
      e.a0    = (own == 0) && sl_ack;
      e.a1    = (own == 1) && sl_ack;
    end
    e.er  = err_now;
    e.eid = err_now && (err_who == 1);
    expq.push_back(e);
    acked[0] = e.a0;
    acked[1] = e.a1;
    err_now = 0;
    if (rst_n) begin
      if (busy) begin
        if (sl_ack) begin
          tie_to = 1 - own; busy = 0; hold_left = RH;
        end else if (!rq_a[own]) begin
          tie_to = 1 - own; busy = 0;
        end else if (waited == TO - 1) begin
          tie_to = 1 - own; busy = 0;
          err_now = 1; err_who = own;
        end else begin
          waited++;
        end
      end else if (hold_left > 0) begin
        hold_left--;
      end else if (reqs != 0) begin
        own    = (reqs == 3) ? tie_to : (reqs == 2 ? 1 : 0);
        busy   = 1;
        waited = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic new_txn(int x);
    rq_a[x] = 1'b1;
    cm_a[x] = 1'($urandom_range(1));
    ad_a[x] = $urandom;
    wd_a[x] = $urandom;
  endtask

  // one cycle of master/slave behaviour, percentages as arguments
  task automatic cycle(int p_ack, int p_start, int p_drop, bit both_on);
    bit dropped;
    dropped = 0;
    for (int x = 0; x < 2; x++) begin
      if (acked[x]) rq_a[x] = 1'b0;
      if (both_on) begin
        if (!rq_a[x]) new_txn(x);
      end else if (rq_a[x] && !acked[x]) begin
        if ($urandom_range(99) < p_drop) begin
          rq_a[x] = 1'b0;
          dropped = 1;
        end
      end else if (!rq_a[x] && $urandom_range(99) < p_start) begin
        new_txn(x);
      end
    end
    sl_ack = !dropped && ($urandom_range(99) < p_ack);
    step();
  endtask

  // monitor: compare every presented cycle against the queued expectation
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      #1;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        g = '0;
        g.g0 = m0_granted; g.g1 = m1_granted;
        g.a0 = m0_ack;     g.a1 = m1_ack;
        g.rq = sl_req;     g.cmd = sl_cmd;
        g.er = err;        g.eid = e.er ? err_id : 1'b0;
        g.addr = sl_addr;  g.wdata = sl_wdata;
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL port_outputs t=%0t got gr=%b%b ack=%b%b req=%b cmd=%b err=%b id=%b addr=%h wd=%h expected gr=%b%b ack=%b%b req=%b cmd=%b err=%b id=%b addr=%h wd=%h",
                   $time, g.g0, g.g1, g.a0, g.a1, g.rq, g.cmd, g.er, g.eid,
                   g.addr, g.wdata, e.g0, e.g1, e.a0, e.a1, e.rq, e.cmd,
                   e.er, e.eid, e.addr, e.wdata);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    sl_ack = 1'b0;
    for (int x = 0; x < 2; x++) begin
      rq_a[x] = 1'b0; cm_a[x] = 1'b0;
      ad_a[x] = '0;   wd_a[x] = '0;
    end
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (800) cycle(40, 30, 2, 0);
    repeat (300) cycle(0, 30, 1, 0);
    repeat (600) cycle(6, 30, 0, 0);
    repeat (60) cycle(100, 0, 0, 1);
    repeat (5) cycle(50, 0, 0, 1);
    rst_n = 1'b0;
    repeat (2) cycle(50, 0, 0, 1);
    rst_n = 1'b1;
    repeat (20) cycle(100, 0, 0, 1);
    repeat (600) cycle(30, 20, 3, 0);
    #2;
    if (compared < 12) begin
      mismatched++;
      $display("FAIL compare_count got %0d required >= 12", compared);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
